hpi_responder: RTL and testbench

Cycle-accurate responder for the four-register OTG HPI bus that the SoC drives from its `otg_hpi_*` exports. The block sits on the far side of that bus in place of the USB controller, for bring-up and for simulation of the keyboard driver without the physical chip. It implements the DATA, MAILBOX, ADDRESS and STATUS registers, plus a word-addressed internal RAM with auto-incrementing access. It also provides a two-way mailbox handshake toward a local device-side agent.

---
 rtl/hpi_responder.sv | 192 +++++++++++++++++++
 tb/tb_hpi_responder.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hpi_responder.sv
// hpi_responder
//
// Stands in for the USB controller on the far side of the four-register OTG
// HPI bus. It lets the SoC keyboard driver be brought up and simulated
// without the physical chip. The block provides four host registers:
//   DATA    (0) - auto-incrementing access to a word-addressed internal RAM
//   MAILBOX (1) - host writes go to the device agent; host reads return the
//                 device response word
//   ADDRESS (2) - 16-bit byte address used by DATA accesses
//   STATUS  (3) - {err, overrun, 5'b0, rx_valid, 7'b0, tx_busy}
//
// Ports:
//   Clk, Reset      system clock, asynchronous active-high reset
//   hpi_addr        register select
//   hpi_data_in     host write data
//   hpi_data_out    registered host read data, held between reads
//   hpi_cs_n/r_n/w_n active-low chip select and strobes
//   hpi_rst_n       active-low synchronous soft reset from the host
//   mbx_rx_data     last host-written mailbox word
//   mbx_rx_valid    host mailbox word pending for the device
//   mbx_rx_ack      device consumes the pending word
//   mbx_tx_data     device response word
//   mbx_tx_valid    one-cycle pulse that loads the response word
//   mbx_tx_busy     response word not yet read by the host

module hpi_responder #(
  parameter int          ADDR_W   = 10,
  parameter logic [15:0] RAM_INIT = 16'h0000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [1:0]  hpi_addr,
  input  logic [15:0] hpi_data_in,
  output logic [15:0] hpi_data_out,
  input  logic        hpi_cs_n,
  input  logic        hpi_r_n,
  input  logic        hpi_w_n,
  input  logic        hpi_rst_n,
  output logic [15:0] mbx_rx_data,
  output logic        mbx_rx_valid,
  input  logic        mbx_rx_ack,
  input  logic [15:0] mbx_tx_data,
  input  logic        mbx_tx_valid,
  output logic        mbx_tx_busy
);

  localparam logic [1:0] REG_DATA    = 2'd0;
  localparam logic [1:0] REG_MAILBOX = 2'd1;
  localparam logic [1:0] REG_ADDRESS = 2'd2;
  localparam logic [1:0] REG_STATUS  = 2'd3;

  localparam int RAM_DEPTH = 1 << ADDR_W;

  // The RAM is left alone by Reset and by the soft reset. It holds RAM_INIT
  // only from configuration.
  logic [15:0] r_ram [RAM_DEPTH] = '{default: RAM_INIT};

  logic [15:0]       r_addr;
  logic [15:0]       r_dataOut;
  logic [15:0]       r_rxData;
  logic              r_rxValid;
  logic [15:0]       r_txData;
  logic              r_txBusy;
  logic              r_err;
  logic              r_ovr;
  logic              r_prevRd;
  logic              r_prevWr;

  logic              w_rd;
  logic              w_wr;
  logic              w_err;
  logic              w_rdEdge;
  logic              w_wrEdge;
  logic              w_ramWe;
  logic [ADDR_W-1:0] w_idx;
  logic [15:0]       w_status;

  // Decode the bus strobes into read, write and protocol-error states. An
  // access acts only in the first cycle it is seen. A strobe held low for
  // many cycles must not repeat the action. Because the error state is
  // excluded from both read and write, a clean strobe that follows an error
  // still counts as a fresh edge.
  always_comb begin
    w_rd     = !hpi_cs_n && !hpi_r_n &&  hpi_w_n;
    w_wr     = !hpi_cs_n && !hpi_w_n &&  hpi_r_n;
    w_err    = !hpi_cs_n && !hpi_r_n && !hpi_w_n;
    w_rdEdge = w_rd && !r_prevRd && hpi_rst_n;
    w_wrEdge = w_wr && !r_prevWr && hpi_rst_n;
    w_ramWe  = w_wrEdge && (hpi_addr == REG_DATA);
    w_idx    = r_addr[ADDR_W:1];
    w_status = {r_err, r_ovr, 5'b0, r_rxValid, 7'b0, r_txBusy};
  end

  // RAM write port. This block has no reset, so the array can map onto
  // block RAM. Bits of the address above ADDR_W simply alias.
  always_ff @(posedge Clk) begin
    if (w_ramWe) begin
      r_ram[w_idx] <= hpi_data_in;
    end
  end

  // All register state lives here. The soft reset clears the address, the
  // sticky status bits and both mailbox flags, and it blocks host accesses.
  // The edge-detect flops keep tracking the strobes so that a strobe held
  // across the soft reset does not fire when the soft reset is released.
  // Priority inside a cycle:
  //   - a host MAILBOX write beats a device ack;
  //   - a device tx load beats the busy-clear from a host MAILBOX read, and
  //     that read still returns the previous word.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_addr    <= '0;
      r_dataOut <= '0;
      r_rxData  <= '0;
      r_rxValid <= 1'b0;
      r_txData  <= '0;
      r_txBusy  <= 1'b0;
      r_err     <= 1'b0;
      r_ovr     <= 1'b0;
      r_prevRd  <= 1'b0;
      r_prevWr  <= 1'b0;
    end else begin
      r_prevRd <= w_rd;
      r_prevWr <= w_wr;
      if (mbx_tx_valid) begin
        r_txData <= mbx_tx_data;
      end
      if (!hpi_rst_n) begin
        r_addr    <= '0;
        r_err     <= 1'b0;
        r_ovr     <= 1'b0;
        r_rxValid <= 1'b0;
        r_txBusy  <= 1'b0;
      end else begin
        if (w_err) begin
          r_err <= 1'b1;
        end
        if (mbx_rx_ack && r_rxValid) begin
          r_rxValid <= 1'b0;
        end
        if (mbx_tx_valid) begin
          r_txBusy <= 1'b1;
        end

        if (w_wrEdge) begin
          case (hpi_addr)
            REG_DATA: r_addr <= r_addr + 16'd2;
            REG_MAILBOX: begin
              r_rxData  <= hpi_data_in;
              r_rxValid <= 1'b1;
              if (r_rxValid && !mbx_rx_ack) begin
                r_ovr <= 1'b1;
              end
            end
            REG_ADDRESS: r_addr <= hpi_data_in;
            REG_STATUS: ;
          endcase
        end

        if (w_rdEdge) begin
          case (hpi_addr)
            REG_DATA: begin
              r_dataOut <= r_ram[w_idx];
              r_addr    <= r_addr + 16'd2;
            end
            REG_MAILBOX: begin
              r_dataOut <= r_txData;
              if (!mbx_tx_valid) begin
                r_txBusy <= 1'b0;
              end
            end
            REG_ADDRESS: r_dataOut <= r_addr;
            REG_STATUS: begin
              r_dataOut <= w_status;
              r_err     <= 1'b0;
              r_ovr     <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  // Drive the outputs straight from their registers.
  always_comb begin
    hpi_data_out = r_dataOut;
    mbx_rx_data  = r_rxData;
    mbx_rx_valid = r_rxValid;
    mbx_tx_busy  = r_txBusy;
  end

endmodule

// File: tb/tb_hpi_responder.sv
// tb_hpi_responder
//
// Directed bench for hpi_responder with the default ADDR_W=10 and
// RAM_INIT=0. Inputs change on the falling clock edge, and outputs are
// sampled on the falling edge, away from the active rising edge.

module tb_hpi_responder;

  logic        Clk;
  logic        Reset;
  logic [1:0]  hpi_addr;
  logic [15:0] hpi_data_in;
  logic [15:0] hpi_data_out;
  logic        hpi_cs_n;
  logic        hpi_r_n;
  logic        hpi_w_n;
  logic        hpi_rst_n;
  logic [15:0] mbx_rx_data;
  logic        mbx_rx_valid;
  logic        mbx_rx_ack;
  logic [15:0] mbx_tx_data;
  logic        mbx_tx_valid;
  logic        mbx_tx_busy;

  int nVectors;
  int nMiscompares;

  hpi_responder dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .hpi_addr     (hpi_addr),
    .hpi_data_in  (hpi_data_in),
    .hpi_data_out (hpi_data_out),
    .hpi_cs_n     (hpi_cs_n),
    .hpi_r_n      (hpi_r_n),
    .hpi_w_n      (hpi_w_n),
    .hpi_rst_n    (hpi_rst_n),
    .mbx_rx_data  (mbx_rx_data),
    .mbx_rx_valid (mbx_rx_valid),
    .mbx_rx_ack   (mbx_rx_ack),
    .mbx_tx_data  (mbx_tx_data),
    .mbx_tx_valid (mbx_tx_valid),
    .mbx_tx_busy  (mbx_tx_busy)
  );

  // Free-running clock with a 10-unit period.
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // One host bus access. A write holds w_n low for one cycle. A read holds
  // r_n low for two cycles and returns hpi_data_out sampled before release.
  // Releasing on a falling edge leaves one idle rising edge before the next
  // access.
  task automatic applyStimulus(input bit isWrite, input logic [1:0] regSel,
                               input logic [15:0] wdata, output logic [15:0] rdata);
    @(negedge Clk);
    hpi_addr = regSel;
    hpi_cs_n = 1'b0;
    if (isWrite) begin
      hpi_data_in = wdata;
      hpi_w_n     = 1'b0;
    end else begin
      hpi_r_n = 1'b0;
    end
    @(negedge Clk);
    if (!isWrite) begin
      @(negedge Clk);
    end
    rdata    = hpi_data_out;
    hpi_cs_n = 1'b1;
    hpi_r_n  = 1'b1;
    hpi_w_n  = 1'b1;
  endtask

  task automatic pulseTx(input logic [15:0] word);
    @(negedge Clk);
    mbx_tx_data  = word;
    mbx_tx_valid = 1'b1;
    @(negedge Clk);
    mbx_tx_valid = 1'b0;
  endtask

  task automatic pulseAck();
    @(negedge Clk);
    mbx_rx_ack = 1'b1;
    @(negedge Clk);
    mbx_rx_ack = 1'b0;
  endtask

  task automatic test_reset();
    logic [15:0] rd;
    Reset        = 1'b1;
    hpi_addr     = 2'd0;
    hpi_data_in  = 16'h0;
    hpi_cs_n     = 1'b1;
    hpi_r_n      = 1'b1;
    hpi_w_n      = 1'b1;
    hpi_rst_n    = 1'b1;
    mbx_rx_ack   = 1'b0;
    mbx_tx_data  = 16'h0;
    mbx_tx_valid = 1'b0;
    repeat (3) @(negedge Clk);
    nVectors++;
    if ({hpi_data_out, mbx_rx_data, mbx_rx_valid, mbx_tx_busy} !== 34'h0) begin
      nMiscompares++;
      $display("[TB] FAIL reset_outputs: got dout=%h rxd=%h rxv=%b busy=%b, want all 0",
               hpi_data_out, mbx_rx_data, mbx_rx_valid, mbx_tx_busy);
    end
    Reset = 1'b0;
    applyStimulus(1'b0, 2'd2, 16'h0, rd);
    nVectors++;
    if (rd !== 16'h0000) begin
      nMiscompares++;
      $display("[TB] FAIL reset_address: got %h want 0000", rd);
    end
    applyStimulus(1'b0, 2'd3, 16'h0, rd);
    nVectors++;
    if (rd !== 16'h0000) begin
      nMiscompares++;
      $display("[TB] FAIL reset_status: got %h want 0000", rd);
    end
  endtask

  task automatic test_ramSequential();
    logic [15:0] rd;
    applyStimulus(1'b1, 2'd2, 16'h0100, rd);
    applyStimulus(1'b1, 2'd0, 16'hAAAA, rd);
    applyStimulus(1'b1, 2'd0, 16'h5555, rd);
    applyStimulus(1'b0, 2'd2, 16'h0, rd);
    nVectors++;
    if (rd !== 16'h0104) begin
      nMiscompares++;
      $display("[TB] FAIL ram_post_inc: got %h want 0104", rd);
    end
    applyStimulus(1'b1, 2'd2, 16'h0100, rd);
    applyStimulus(1'b0, 2'd0, 16'h0, rd);
    nVectors++;
    if (rd !== 16'hAAAA) begin
      nMiscompares++;
      $display("[TB] FAIL ram_read0: got %h want AAAA", rd);
    end
    applyStimulus(1'b0, 2'd0, 16'h0, rd);
    nVectors++;
    if (rd !== 16'h5555) begin
      nMiscompares++;
      $display("[TB] FAIL ram_read1: got %h want 5555", rd);
    end
  endtask

  task automatic test_longRead();
    logic [15:0] rd;
    applyStimulus(1'b1, 2'd2, 16'h0100, rd);
    @(negedge Clk);
    hpi_addr = 2'd0;
    hpi_cs_n = 1'b0;
    hpi_r_n  = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      nVectors++;
      if (hpi_data_out !== 16'hAAAA) begin
        nMiscompares++;
        $display("[TB] FAIL long_read_hold[%0d]: got %h want AAAA", i, hpi_data_out);
      end
    end
    hpi_cs_n = 1'b1;
    hpi_r_n  = 1'b1;
    applyStimulus(1'b0, 2'd2, 16'h0, rd);
    nVectors++;
    if (rd !== 16'h0102) begin
      nMiscompares++;
      $display("[TB] FAIL long_read_single_inc: got %h want 0102", rd);
    end
  endtask

  task automatic test_addressWrap();
    logic [15:0] rd;
    applyStimulus(1'b1, 2'd2, 16'hFFFE, rd);
    applyStimulus(1'b1, 2'd0, 16'h1234, rd);
    applyStimulus(1'b0, 2'd2, 16'h0, rd);
    nVectors++;
    if (rd !== 16'h0000) begin
      nMiscompares++;
      $display("[TB] FAIL wrap_address: got %h want 0000", rd);
    end
    applyStimulus(1'b1, 2'd2, 16'h07FE, rd);
    applyStimulus(1'b0, 2'd0, 16'h0, rd);
    nVectors++;
    if (rd !== 16'h1234) begin
      nMiscompares++;
      $display("[TB] FAIL wrap_word_3ff: got %h want 1234", rd);
    end
    applyStimulus(1'b1, 2'd2, 16'h0FFF, rd);
    applyStimulus(1'b0, 2'd0, 16'h0, rd);
    nVectors++;
    if (rd !== 16'h1234) begin
      nMiscompares++;
      $display("[TB] FAIL alias_bit0_ignored: got %h want 1234", rd);
    end
  endtask

  task automatic test_mailboxRx();
    logic [15:0] rd;
    applyStimulus(1'b1, 2'd1, 16'h00C3, rd);
    nVectors++;
    if (mbx_rx_valid !== 1'b1 || mbx_rx_data !== 16'h00C3) begin
      nMiscompares++;
      $display("[TB] FAIL rx_first_write: got valid=%b data=%h want 1/00C3",
               mbx_rx_valid, mbx_rx_data);
    end
    applyStimulus(1'b0, 2'd3, 16'h0, rd);
    nVectors++;
    if (rd !== 16'h0100) begin
      nMiscompares++;
      $display("[TB] FAIL rx_status_pending: got %h want 0100", rd);
    end
    applyStimulus(1'b1, 2'd1, 16'h0055, rd);
    applyStimulus(1'b0, 2'd3, 16'h0, rd);
    nVectors++;
    if (rd !== 16'h4100) begin
      nMiscompares++;
      $display("[TB] FAIL rx_status_overrun: got %h want 4100", rd);
    end
    applyStimulus(1'b0, 2'd3, 16'h0, rd);
    nVectors++;
    if (rd !== 16'h0100) begin
      nMiscompares++;
      $display("[TB] FAIL rx_status_sticky_clear: got %h want 0100", rd);
    end
    pulseAck();
    nVectors++;
    if (mbx_rx_valid !== 1'b0 || mbx_rx_data !== 16'h0055) begin
      nMiscompares++;
      $display("[TB] FAIL rx_ack: got valid=%b data=%h want 0/0055", mbx_rx_valid, mbx_rx_data);
    end
  endtask

  task automatic test_mailboxTx();
    logic [15:0] rd;
    pulseTx(16'hBEEF);
    applyStimulus(1'b0, 2'd3, 16'h0, rd);
    nVectors++;
    if (rd !== 16'h0001) begin
      nMiscompares++;
      $display("[TB] FAIL tx_status_busy: got %h want 0001", rd);
    end
    applyStimulus(1'b0, 2'd1, 16'h0, rd);
    nVectors++;
    if (rd !== 16'hBEEF || mbx_tx_busy !== 1'b0) begin
      nMiscompares++;
      $display("[TB] FAIL tx_host_read: got data=%h busy=%b want BEEF/0", rd, mbx_tx_busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] rd;
    pulseTx(16'h1111);
    @(negedge Clk);
    hpi_addr     = 2'd1;
    hpi_cs_n     = 1'b0;
    hpi_r_n      = 1'b0;
    mbx_tx_data  = 16'h2222;
    mbx_tx_valid = 1'b1;
    @(negedge Clk);
    mbx_tx_valid = 1'b0;
    @(negedge Clk);
    nVectors++;
    if (hpi_data_out !== 16'h1111 || mbx_tx_busy !== 1'b1) begin
      nMiscompares++;
      $display("[TB] FAIL tx_coincident: got data=%h busy=%b want 1111/1", hpi_data_out, mbx_tx_busy);
    end
    hpi_cs_n = 1'b1;
    hpi_r_n  = 1'b1;
    applyStimulus(1'b0, 2'd1, 16'h0, rd);
    nVectors++;
    if (rd !== 16'h2222 || mbx_tx_busy !== 1'b0) begin
      nMiscompares++;
      $display("[TB] FAIL tx_new_word: got data=%h busy=%b want 2222/0", rd, mbx_tx_busy);
    end
    applyStimulus(1'b1, 2'd1, 16'h0011, rd);
    @(negedge Clk);
    hpi_addr    = 2'd1;
    hpi_data_in = 16'h0022;
    hpi_cs_n    = 1'b0;
    hpi_w_n     = 1'b0;
    mbx_rx_ack  = 1'b1;
    @(negedge Clk);
    hpi_cs_n   = 1'b1;
    hpi_w_n    = 1'b1;
    mbx_rx_ack = 1'b0;
    nVectors++;
    if (mbx_rx_valid !== 1'b1 || mbx_rx_data !== 16'h0022) begin
      nMiscompares++;
      $display("[TB] FAIL rx_write_beats_ack: got valid=%b data=%h want 1/0022",
               mbx_rx_valid, mbx_rx_data);
    end
    pulseAck();
    applyStimulus(1'b0, 2'd3, 16'h0, rd);
  endtask

  task automatic test_protocolError();
    logic [15:0] rd;
    applyStimulus(1'b1, 2'd2, 16'h0200, rd);
    @(negedge Clk);
    hpi_addr    = 2'd0;
    hpi_data_in = 16'hDEAD;
    hpi_cs_n    = 1'b0;
    hpi_r_n     = 1'b0;
    hpi_w_n     = 1'b0;
    repeat (2) @(negedge Clk);
    hpi_cs_n = 1'b1;
    hpi_r_n  = 1'b1;
    hpi_w_n  = 1'b1;
    applyStimulus(1'b0, 2'd2, 16'h0, rd);
    nVectors++;
    if (rd !== 16'h0200) begin
      nMiscompares++;
      $display("[TB] FAIL err_address_kept: got %h want 0200", rd);
    end
    applyStimulus(1'b0, 2'd3, 16'h0, rd);
    nVectors++;
    if (rd !== 16'h8000) begin
      nMiscompares++;
      $display("[TB] FAIL err_status_set: got %h want 8000", rd);
    end
    applyStimulus(1'b0, 2'd3, 16'h0, rd);
    nVectors++;
    if (rd !== 16'h0000) begin
      nMiscompares++;
      $display("[TB] FAIL err_status_cleared: got %h want 0000", rd);
    end
    applyStimulus(1'b0, 2'd0, 16'h0, rd);
    nVectors++;
    if (rd !== 16'h0000) begin
      nMiscompares++;
      $display("[TB] FAIL err_ram_untouched: got %h want 0000", rd);
    end
  endtask

  task automatic test_softReset();
    logic [15:0] rd;
    applyStimulus(1'b1, 2'd2, 16'h0100, rd);
    applyStimulus(1'b1, 2'd1, 16'h0077, rd);
    pulseTx(16'h3333);
    @(negedge Clk);
    hpi_rst_n = 1'b0;
    applyStimulus(1'b1, 2'd2, 16'h0300, rd);
    @(negedge Clk);
    hpi_rst_n = 1'b1;
    nVectors++;
    if (mbx_rx_valid !== 1'b0 || mbx_tx_busy !== 1'b0) begin
      nMiscompares++;
      $display("[TB] FAIL soft_reset_flags: got valid=%b busy=%b want 0/0", mbx_rx_valid, mbx_tx_busy);
    end
    applyStimulus(1'b0, 2'd2, 16'h0, rd);
    nVectors++;
    if (rd !== 16'h0000) begin
      nMiscompares++;
      $display("[TB] FAIL soft_reset_address: got %h want 0000", rd);
    end
    applyStimulus(1'b1, 2'd2, 16'h0100, rd);
    applyStimulus(1'b0, 2'd0, 16'h0, rd);
    nVectors++;
    if (rd !== 16'hAAAA) begin
      nMiscompares++;
      $display("[TB] FAIL soft_reset_ram0: got %h want AAAA", rd);
    end
    applyStimulus(1'b0, 2'd0, 16'h0, rd);
    nVectors++;
    if (rd !== 16'h5555) begin
      nMiscompares++;
      $display("[TB] FAIL soft_reset_ram1: got %h want 5555", rd);
    end
  endtask

  // Run every scenario in order and finish with the summary line.
  initial begin
    nVectors     = 0;
    nMiscompares = 0;
    test_reset();
    test_ramSequential();
    test_longRead();
    test_addressWrap();
    test_mailboxRx();
    test_mailboxTx();
    test_back_to_back();
    test_protocolError();
    test_softReset();
    repeat (2) @(negedge Clk);
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
